// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ID instruction into ALU control, resolves
// forwarded operands and immediates, and registers everything for the EX stage.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        exm_wr_en,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_data,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] store_data,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        valid_out,
  output logic        illegal
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 3;

  localparam logic [CW-1:0] ALU_ADD = 3'b000;
  localparam logic [CW-1:0] ALU_SUB = 3'b001;
  localparam logic [CW-1:0] ALU_XOR = 3'b010;
  localparam logic [CW-1:0] ALU_BEQ = 3'b011;
  localparam logic [CW-1:0] ALU_OR  = 3'b100;

  // EX/MEM result beats WB result; r0 always reads as zero.
  function automatic logic [DW-1:0] fwd(
    input logic [RW-1:0] r,
    input logic [DW-1:0] rf,
    input logic          ew,
    input logic [RW-1:0] er,
    input logic [DW-1:0] ed,
    input logic          ww,
    input logic [RW-1:0] wr,
    input logic [DW-1:0] wd
  );
    if (r == '0)                 return '0;
    else if (ew && (er == r))    return ed;
    else if (ww && (wr == r))    return wd;
    else                         return rf;
  endfunction

  logic [DW-1:0] fwd_rs, fwd_rt, sext, zext;
  logic          dec_ok, dec_rw, dec_mr, dec_mw;
  logic [CW-1:0] dec_ctrl;
  logic [DW-1:0] dec_b;
  logic [RW-1:0] dec_dest;
  logic          take, bad;

  always_comb begin
    fwd_rs = fwd(rs, rs_data, exm_wr_en, exm_rd, exm_data, wb_wr_en, wb_rd, wb_data);
    fwd_rt = fwd(rt, rt_data, exm_wr_en, exm_rd, exm_data, wb_wr_en, wb_rd, wb_data);
    sext   = {{16{imm16[15]}}, imm16};
    zext   = {16'h0000, imm16};
  end

  // Instruction decode
  always_comb begin
    dec_ok   = 1'b0;
    dec_ctrl = ALU_ADD;
    dec_b    = '0;
    dec_dest = '0;
    dec_rw   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    case (opcode)
      6'h00: begin
        dec_b    = fwd_rt;
        dec_dest = rd;
        dec_rw   = 1'b1;
        case (funct)
          6'h20:   begin dec_ok = 1'b1; dec_ctrl = ALU_ADD; end
          6'h22:   begin dec_ok = 1'b1; dec_ctrl = ALU_SUB; end
          6'h25:   begin dec_ok = 1'b1; dec_ctrl = ALU_OR;  end
          6'h26:   begin dec_ok = 1'b1; dec_ctrl = ALU_XOR; end
          default: dec_ok = 1'b0;
        endcase
      end
      6'h08: begin dec_ok = 1'b1; dec_ctrl = ALU_ADD; dec_b = sext; dec_dest = rt; dec_rw = 1'b1; end
      6'h0D: begin dec_ok = 1'b1; dec_ctrl = ALU_OR;  dec_b = zext; dec_dest = rt; dec_rw = 1'b1; end
      6'h0E: begin dec_ok = 1'b1; dec_ctrl = ALU_XOR; dec_b = zext; dec_dest = rt; dec_rw = 1'b1; end
      6'h23: begin
        dec_ok = 1'b1; dec_ctrl = ALU_ADD; dec_b = sext; dec_dest = rt; dec_rw = 1'b1; dec_mr = 1'b1;
      end
      6'h2B: begin dec_ok = 1'b1; dec_ctrl = ALU_ADD; dec_b = sext; dec_mw = 1'b1; end
      6'h04: begin dec_ok = 1'b1; dec_ctrl = ALU_BEQ; dec_b = fwd_rt; end
      default: dec_ok = 1'b0;
    endcase
    take = valid_in && dec_ok && !flush;
    bad  = valid_in && !dec_ok && !flush;
  end

  // Pipeline register: reset > flush > stall > load; non-taken loads become bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      store_data <= '0;
      dest_reg   <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      valid_out  <= 1'b0;
      illegal    <= 1'b0;
    end else if (stall && !flush) begin
      illegal    <= 1'b0;
    end else begin
      alu_a      <= take ? fwd_rs   : '0;
      alu_b      <= take ? dec_b    : '0;
      alu_ctrl   <= take ? dec_ctrl : ALU_ADD;
      store_data <= take ? fwd_rt   : '0;
      dest_reg   <= take ? dec_dest : '0;
      reg_write  <= take && dec_rw && (dec_dest != '0);
      mem_read   <= take && dec_mr;
      mem_write  <= take && dec_mw;
      valid_out  <= take;
      illegal    <= bad;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: table of decode/forwarding cases plus
// hand sequences for reset, stall, flush and the illegal pulse.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, valid_in, stall, flush;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, exm_rd, wb_rd;
  logic [15:0] imm16;
  logic [31:0] rs_data, rt_data, exm_data, wb_data;
  logic        exm_wr_en, wb_wr_en;
  logic [31:0] alu_a, alu_b, store_data;
  logic [2:0]  alu_ctrl;
  logic [4:0]  dest_reg;
  logic        reg_write, mem_read, mem_write, valid_out, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .rs_data(rs_data), .rt_data(rt_data),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .store_data(store_data),
    .dest_reg(dest_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .valid_out(valid_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] rsd, rtd;
    logic        ew;
    logic [4:0]  er;
    logic [31:0] ed;
    logic        ww;
    logic [4:0]  wr;
    logic [31:0] wd;
  } in_t;

  typedef struct {
    logic [31:0] a, b, sd;
    logic [2:0]  c;
    logic [4:0]  d;
    logic        rw, mr, mw, vo, il;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  function automatic in_t mi(logic v, logic [5:0] op, logic [5:0] fn, logic [4:0] a, logic [4:0] b,
                             logic [4:0] d, logic [15:0] imm, logic [31:0] rsd, logic [31:0] rtd);
    in_t x;
    x.v = v; x.op = op; x.fn = fn; x.rs = a; x.rt = b; x.rd = d; x.imm = imm;
    x.rsd = rsd; x.rtd = rtd;
    x.ew = 1'b0; x.er = '0; x.ed = '0; x.ww = 1'b0; x.wr = '0; x.wd = '0;
    return x;
  endfunction

  function automatic in_t fw(in_t x, logic ew, logic [4:0] er, logic [31:0] ed,
                             logic ww, logic [4:0] wr, logic [31:0] wd);
    in_t y = x;
    y.ew = ew; y.er = er; y.ed = ed; y.ww = ww; y.wr = wr; y.wd = wd;
    return y;
  endfunction

  function automatic out_t mo(logic [31:0] a, logic [31:0] b, logic [2:0] c, logic [31:0] sd,
                              logic [4:0] d, logic rw, logic mr, logic mw, logic vo, logic il);
    out_t o;
    o.a = a; o.b = b; o.c = c; o.sd = sd; o.d = d;
    o.rw = rw; o.mr = mr; o.mw = mw; o.vo = vo; o.il = il;
    return o;
  endfunction

  function automatic vec_t mv(string nm, in_t i, out_t o);
    vec_t x;
    x.name = nm; x.i = i; x.o = o;
    return x;
  endfunction

  task automatic apply(in_t x);
    valid_in = x.v; opcode = x.op; funct = x.fn; rs = x.rs; rt = x.rt; rd = x.rd;
    imm16 = x.imm; rs_data = x.rsd; rt_data = x.rtd;
    exm_wr_en = x.ew; exm_rd = x.er; exm_data = x.ed;
    wb_wr_en = x.ww; wb_rd = x.wr; wb_data = x.wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_out(string nm, out_t e);
    chk({nm, ".alu_a"},      alu_a,             e.a);
    chk({nm, ".alu_b"},      alu_b,             e.b);
    chk({nm, ".alu_ctrl"},   32'(alu_ctrl),     32'(e.c));
    chk({nm, ".store_data"}, store_data,        e.sd);
    chk({nm, ".dest_reg"},   32'(dest_reg),     32'(e.d));
    chk({nm, ".reg_write"},  32'(reg_write),    32'(e.rw));
    chk({nm, ".mem_read"},   32'(mem_read),     32'(e.mr));
    chk({nm, ".mem_write"},  32'(mem_write),    32'(e.mw));
    chk({nm, ".valid_out"},  32'(valid_out),    32'(e.vo));
    chk({nm, ".illegal"},    32'(illegal),      32'(e.il));
  endtask

  vec_t vecs[$];
  out_t zero_o, ill_o, lw_o, add_o;
  in_t  lw_i, add_i, add2_i, bad_i, idle_i;

  initial begin
    zero_o = mo(0, 0, 3'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    ill_o  = mo(0, 0, 3'd0, 0, 5'd0, 0, 0, 0, 0, 1);
    idle_i = mi(1'b0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 32'd5, 32'd7);
    add_i  = mi(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 32'd5, 32'd7);
    add_o  = mo(32'd5, 32'd7, 3'b000, 32'd7, 5'd3, 1, 0, 0, 1, 0);
    add2_i = mi(1'b1, 6'h00, 6'h26, 5'd6, 5'd7, 5'd9, 16'h1234, 32'hAAAA0000, 32'h0000BBBB);
    lw_i   = mi(1'b1, 6'h23, 6'h00, 5'd1, 5'd10, 5'd0, 16'h0004, 32'd100, 32'h77);
    lw_o   = mo(32'd100, 32'd4, 3'b000, 32'h77, 5'd10, 1, 1, 0, 1, 0);
    bad_i  = mi(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 16'h0, 32'd5, 32'd7);

    vecs.push_back(mv("add", add_i, add_o));
    vecs.push_back(mv("sub_fwd_prio",
      fw(mi(1, 6'h00, 6'h22, 5'd1, 5'd1, 5'd4, 16'h0, 32'd99, 32'd99), 1, 5'd1, 32'h10, 1, 5'd1, 32'h20),
      mo(32'h10, 32'h10, 3'b001, 32'h10, 5'd4, 1, 0, 0, 1, 0)));
    vecs.push_back(mv("sub_rs0",
      fw(mi(1, 6'h00, 6'h22, 5'd0, 5'd1, 5'd4, 16'h0, 32'd99, 32'd99), 1, 5'd1, 32'h10, 1, 5'd1, 32'h20),
      mo(32'h0, 32'h10, 3'b001, 32'h10, 5'd4, 1, 0, 0, 1, 0)));
    vecs.push_back(mv("or_wb_fwd",
      fw(mi(1, 6'h00, 6'h25, 5'd2, 5'd6, 5'd5, 16'h0, 32'd1, 32'h66), 1, 5'd7, 32'h70, 1, 5'd2, 32'h20),
      mo(32'h20, 32'h66, 3'b100, 32'h66, 5'd5, 1, 0, 0, 1, 0)));
    vecs.push_back(mv("xor_exm_dis",
      fw(mi(1, 6'h00, 6'h26, 5'd1, 5'd2, 5'd7, 16'h0, 32'd1, 32'd2), 0, 5'd1, 32'h55, 0, 5'd2, 32'h66),
      mo(32'd1, 32'd2, 3'b010, 32'd2, 5'd7, 1, 0, 0, 1, 0)));
    vecs.push_back(mv("addi_sext",
      mi(1, 6'h08, 6'h00, 5'd1, 5'd8, 5'd0, 16'hFFFF, 32'd3, 32'h88),
      mo(32'd3, 32'hFFFFFFFF, 3'b000, 32'h88, 5'd8, 1, 0, 0, 1, 0)));
    vecs.push_back(mv("ori_zext",
      mi(1, 6'h0D, 6'h00, 5'd1, 5'd9, 5'd0, 16'hFFFF, 32'd3, 32'h99),
      mo(32'd3, 32'h0000FFFF, 3'b100, 32'h99, 5'd9, 1, 0, 0, 1, 0)));
    vecs.push_back(mv("xori_zext",
      mi(1, 6'h0E, 6'h00, 5'd1, 5'd9, 5'd0, 16'h8000, 32'd3, 32'h99),
      mo(32'd3, 32'h00008000, 3'b010, 32'h99, 5'd9, 1, 0, 0, 1, 0)));
    vecs.push_back(mv("lw", lw_i, lw_o));
    vecs.push_back(mv("sw",
      mi(1, 6'h2B, 6'h00, 5'd1, 5'd11, 5'd0, 16'hFFFC, 32'd100, 32'hAB),
      mo(32'd100, 32'hFFFFFFFC, 3'b000, 32'hAB, 5'd0, 0, 0, 1, 1, 0)));
    vecs.push_back(mv("beq",
      mi(1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0010, 32'd5, 32'd5),
      mo(32'd5, 32'd5, 3'b011, 32'd5, 5'd0, 0, 0, 0, 1, 0)));
    vecs.push_back(mv("addi_r0",
      mi(1, 6'h08, 6'h00, 5'd1, 5'd0, 5'd0, 16'h0001, 32'd3, 32'h0),
      mo(32'd3, 32'd1, 3'b000, 32'd0, 5'd0, 0, 0, 0, 1, 0)));
    vecs.push_back(mv("idle", idle_i, zero_o));
    vecs.push_back(mv("bad_funct", mi(1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 16'h0, 32'd5, 32'd7), ill_o));
    vecs.push_back(mv("bad_opcode", bad_i, ill_o));
    vecs.push_back(mv("after_ill", idle_i, zero_o));

    // Reset with random inputs, then idle release
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    apply(mi(1'b1, 6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), $urandom, $urandom));
    step();
    apply(mi(1'b1, 6'h00, 6'h20, 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), $urandom, $urandom));
    step();
    check_out("reset", zero_o);
    reset = 1'b0;
    apply(idle_i);
    step();
    check_out("reset_idle", zero_o);

    foreach (vecs[k]) begin
      apply(vecs[k].i);
      step();
      check_out(vecs[k].name, vecs[k].o);
    end

    // Stall holds lw result for 3 cycles while inputs change
    apply(lw_i);
    step();
    check_out("stall_load", lw_o);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply(c == 1 ? bad_i : add2_i);
      step();
      check_out($sformatf("stall_hold%0d", c), lw_o);
    end
    stall = 1'b0;
    apply(add_i);
    step();
    check_out("stall_release", add_o);

    // illegal pulse clears during a stall; bubble outputs hold
    apply(bad_i);
    step();
    check_out("ill_pre_stall", ill_o);
    stall = 1'b1;
    apply(add_i);
    step();
    check_out("ill_in_stall", zero_o);
    stall = 1'b0;

    // flush beats stall; flush suppresses illegal
    apply(add_i);
    step();
    check_out("pre_flush", add_o);
    stall = 1'b1; flush = 1'b1;
    step();
    check_out("stall_flush", zero_o);
    stall = 1'b0;
    apply(bad_i);
    step();
    check_out("flush_bad", zero_o);
    flush = 1'b0;

    // Mid-stream reset, then first capture is a normal load
    apply(lw_i);
    step();
    check_out("pre_reset", lw_o);
    reset = 1'b1; flush = 1'b0;
    apply(add_i);
    step();
    check_out("mid_reset", zero_o);
    reset = 1'b0;
    step();
    check_out("post_reset", add_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
